dst_act_pool: RTL and testbench
===============================

// Module: dst_act_pool
// PURPOSE
//  Downstream stage on the result stream of the DNN top: consumes the dst_valid/dst_data/dst_last
//  stream of real values, applies optional ReLU, then optional 2x2/stride-2 max pooling.
//  Emits a pooled real stream toward DMA or the next layer's src stream.
//  Frame = od+1 channels, each oh+1 rows of ow+1 values; row-major within channel, channel-major.
// PARAMETERS
//  MAXW    32   max supported row width (ow+1); line buffer holds MAXW/2 entries
// PORTS
//  clk        in   1     clock
//  rst        in   1     synchronous active-high reset
//  relu       in   1     1: x = max(x,0.0) before pooling; sampled when frame idle
//  pool       in   1     1: 2x2 max pool; 0: pass-through (after optional ReLU)
//  od         in   4     channels-1
//  oh         in   5     rows-1
//  ow         in   5     cols-1
//  in_valid   in   1     upstream data valid (dst_valid of top)
//  in_data    in   real  upstream value
//  in_last    in   1     upstream frame end
//  in_ready   out  1     stage accepts in_data
//  out_valid  out  1     pooled value valid
//  out_data   out  real  pooled value
//  out_last   out  1     final output of frame
//  out_ready  in   1     downstream accepts
//  frame_err  out  1     sticky: in_last disagreed with counters; cleared by rst
// BEHAVIOUR
//  - Reset: in_ready=0 on the reset cycle and 1 afterwards. out_valid=0, out_last=0, out_data=0.0,
//    frame_err=0. Counters c/r/x=0. Pair/hold regs=0.0. State=IDLE.
//  - Accept when in_valid & in_ready; in_ready = ~out_valid | out_ready (1-entry output reg, no bubble).
//  - States:
//    IDLE: on first accept, latch relu/pool/od/oh/ow and go to RUN.
//    RUN: on the accept that completes c=od, r=oh, x=ow, go to IDLE.
//    Config changes while in RUN are ignored.
//  - Counters x->r->c wrap: x==ow -> x=0, r++; r==oh -> r=0, c++.
//  - pool=0: every accept loads out_valid/out_data next cycle (latency 1).
//    out_last = the accept is the frame's final element.
//  - pool=1 (v = post-ReLU value):
//    - even r, even x: pair = v.
//    - even r, odd x: lbuf[x>>1] = max(pair,v).
//    - odd r, even x: pair = v.
//    - odd r, odd x: out_data = max(lbuf[x>>1], pair, v), out_valid next cycle.
//    - Odd ow+1 or oh+1: the trailing column/row is consumed but contributes nothing (floor).
//    - out_last is set on the final emitted output, i.e. (r,x) = last odd pair of the last channel.
//    - If no output exists (oh=0 or ow=0 with pool=1), no out_last is emitted.
//  - max() on reals; comparisons treat -0.0 == 0.0. ReLU of -0.0 -> 0.0.
//  - in_last on a non-final element: frame_err<=1, counters reset to 0, state IDLE. The element
//    itself is processed normally and out_last is forced on any output it produces.
//  - Final element without in_last: frame_err<=1, frame still closes by counters.
//  - Output held stable while out_valid & ~out_ready. Simultaneous out_ready and new accept:
//    the output register reloads in the same cycle.
//  - rst mid-frame: all state and the output reg are dropped immediately; the partial frame is lost.
// STRUCTURE
//  - tiny_dnn_pkg: typedef enum {IDLE,RUN} dap_state_t; typedef struct {relu,pool,od,oh,ow} dap_cfg_t;
//    function real rmax(real a, real b).
//  - Sub-module pool_line_buf: MAXW/2 x real, 1 write/1 read, write-first; read is combinational
//    on address x>>1.
// TESTING
//  1. pool=0 relu=1, od=0 oh=0 ow=3, in {-1.5,2.0,-0.0,3.25} -> out {0.0,2.0,0.0,3.25};
//     out_last on 4th output; each output 1 cycle after its accept.
//  2. pool=1 relu=0, od=0 oh=1 ow=3, rows {1,5,2,0},{3,4,-7,9} -> out {5,9}; out_last on 9.
//  3. pool=1, od=1 oh=2 ow=2 (3x3, two channels) -> 1 output per channel; the third row/column
//     is dropped; out_last only on channel 1's output.
//  4. out_ready held 0 for 5 cycles during test 2 -> in_ready drops after first pending output;
//     no loss or duplication; out_data stable while stalled.
//  5. in_last asserted on element 2 of a 4-element frame -> frame_err=1; next frame is
//     processed from counters 0 correctly.
//  6. rst asserted mid-frame in test 2 after 3 accepts -> out_valid=0 next cycle; a fresh
//     frame gives the exact test-2 result.

Source files
------------

// File: rtl/tiny_dnn_pkg.sv
// Shared types and real-valued helpers for the activation/pooling stage.
package tiny_dnn_pkg;

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} dap_state_t;

  typedef struct packed {
    logic       relu;
    logic       pool;
    logic [3:0] od;
    logic [4:0] oh;
    logic [4:0] ow;
  } dap_cfg_t;

  // Ties return the first operand, so -0.0 and 0.0 compare equal.
  function automatic real rmax(real a, real b);
    return (b > a) ? b : a;
  endfunction

  // Negative zero is not greater than 0.0, so it maps to +0.0.
  function automatic real relu0(real a);
    return (a > 0.0) ? a : 0.0;
  endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Half-row line buffer holding horizontal pair maxima between even and odd rows.
module pool_line_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  real           wdata,
  input  logic [AW-1:0] raddr,
  output real           rdata
);

  real mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Write-first: a same-cycle write to the read address is forwarded.
  always_comb begin
    rdata = mem[raddr];
    if (we && (waddr == raddr)) rdata = wdata;
  end

endmodule

// File: rtl/dst_act_pool.sv
// ReLU plus optional 2x2/stride-2 max pooling on the DNN result stream, with a
// one-entry output register and frame-boundary checking against in_last.
module dst_act_pool
  import tiny_dnn_pkg::*;
#(
  parameter int MAXW = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       relu,
  input  logic       pool,
  input  logic [3:0] od,
  input  logic [4:0] oh,
  input  logic [4:0] ow,
  input  logic       in_valid,
  input  real        in_data,
  input  logic       in_last,
  output logic       in_ready,
  output logic       out_valid,
  output real        out_data,
  output logic       out_last,
  input  logic       out_ready,
  output logic       frame_err
);

  localparam int DEPTH = MAXW / 2;
  localparam int AW    = $clog2(DEPTH);

  dap_state_t state_q, state_d;
  dap_cfg_t   cfg_q, cfg_d, cfg_eff;
  logic [3:0] c_q, c_d;
  logic [4:0] r_q, r_d, x_q, x_d;
  real        pair_q, pair_d;
  logic       out_valid_q, out_valid_d;
  real        out_data_q, out_data_d;
  logic       out_last_q, out_last_d;
  logic       frame_err_q, frame_err_d;

  logic          accept, is_final, early_last, pool_last;
  real           v, lb_rd, lb_wdata;
  logic          lb_we;
  logic [AW-1:0] lb_addr;

  assign in_ready  = ~rst & (~out_valid_q | out_ready);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign frame_err = frame_err_q;

  pool_line_buf #(.DEPTH(DEPTH), .AW(AW)) u_lbuf (
    .clk   (clk),
    .we    (lb_we),
    .waddr (lb_addr),
    .wdata (lb_wdata),
    .raddr (lb_addr),
    .rdata (lb_rd)
  );

  always_comb begin
    // Configuration follows the ports only while no frame is in flight.
    cfg_eff      = (state_q == IDLE) ? {relu, pool, od, oh, ow} : cfg_q;
    accept       = in_valid & in_ready;
    v            = cfg_eff.relu ? relu0(in_data) : in_data;
    is_final     = (c_q == cfg_eff.od) && (r_q == cfg_eff.oh) && (x_q == cfg_eff.ow);
    early_last   = in_last & ~is_final;
    // Last complete 2x2 window: odd row/col that is either the last or next-to-last index.
    pool_last    = (c_q == cfg_eff.od) &&
                   ((r_q == cfg_eff.oh) || ((r_q + 5'd1) == cfg_eff.oh)) &&
                   ((x_q == cfg_eff.ow) || ((x_q + 5'd1) == cfg_eff.ow));
    lb_addr      = AW'(x_q >> 1);
    lb_wdata     = rmax(pair_q, v);
    lb_we        = accept & cfg_eff.pool & ~r_q[0] & x_q[0];

    state_d      = state_q;
    cfg_d        = cfg_q;
    c_d          = c_q;
    r_d          = r_q;
    x_d          = x_q;
    pair_d       = pair_q;
    out_valid_d  = out_valid_q & ~out_ready;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q & ~out_ready;
    frame_err_d  = frame_err_q;

    if (accept) begin
      if (!cfg_eff.pool) begin
        out_valid_d = 1'b1;
        out_data_d  = v;
        out_last_d  = is_final | in_last;
      end else begin
        if (!x_q[0]) pair_d = v;
        if (r_q[0] && x_q[0]) begin
          out_valid_d = 1'b1;
          out_data_d  = rmax(rmax(lb_rd, pair_q), v);
          out_last_d  = pool_last | in_last;
        end
      end

      frame_err_d = frame_err_q | early_last | (is_final & ~in_last);
      if (state_q == IDLE) cfg_d = cfg_eff;

      if (early_last || is_final) begin
        state_d = IDLE;
        c_d     = '0;
        r_d     = '0;
        x_d     = '0;
      end else begin
        state_d = RUN;
        if (x_q == cfg_eff.ow) begin
          x_d = '0;
          if (r_q == cfg_eff.oh) begin
            r_d = '0;
            c_d = c_q + 4'd1;
          end else begin
            r_d = r_q + 5'd1;
          end
        end else begin
          x_d = x_q + 5'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cfg_q       <= '0;
      c_q         <= '0;
      r_q         <= '0;
      x_q         <= '0;
      pair_q      <= 0.0;
      out_valid_q <= 1'b0;
      out_data_q  <= 0.0;
      out_last_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cfg_q       <= cfg_d;
      c_q         <= c_d;
      r_q         <= r_d;
      x_q         <= x_d;
      pair_q      <= pair_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      frame_err_q <= frame_err_d;
    end
  end

endmodule

// File: tb/tb_dst_act_pool.sv
// Directed bench for dst_act_pool: ReLU pass-through, 2x2 pooling, stalls,
// frame errors and mid-frame reset, checked with immediate assertions.
module tb_dst_act_pool;

  logic       clk = 1'b0;
  logic       rst;
  logic       relu, pool;
  logic [3:0] od;
  logic [4:0] oh, ow;
  logic       in_valid, in_last, in_ready;
  real        in_data;
  logic       out_valid, out_last, out_ready, frame_err;
  real        out_data;

  int n_assert = 0;
  int n_fail   = 0;

  dst_act_pool #(.MAXW(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .relu      (relu),
    .pool      (pool),
    .od        (od),
    .oh        (oh),
    .ow        (ow),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk_l(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk_r(input string tag, input real obs, input real exp);
    n_assert++;
    assert (obs == exp) else begin
      n_fail++;
      $error("FAIL %s: observed %f expected %f", tag, obs, exp);
    end
  endtask

  // One accepted element; outputs sampled 1 time unit after the accepting edge.
  task automatic send(input string tag, input real d, input logic last,
                      input logic ev, input real ed, input logic el);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    #1;
    chk_l({tag, " in_ready"}, in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk_l({tag, " out_valid"}, out_valid, ev);
    if (ev) begin
      chk_r({tag, " out_data"}, out_data, ed);
      chk_l({tag, " out_last"}, out_last, el);
    end
  endtask

  task automatic cfg(input logic rl, input logic pl, input logic [3:0] d,
                     input logic [4:0] h, input logic [4:0] w);
    relu = rl; pool = pl; od = d; oh = h; ow = w;
  endtask

  task automatic test2_frame(input string tag);
    send(tag, 1.0, 1'b0, 1'b0, 0.0, 1'b0);
    send(tag, 5.0, 1'b0, 1'b0, 0.0, 1'b0);
    send(tag, 2.0, 1'b0, 1'b0, 0.0, 1'b0);
    send(tag, 0.0, 1'b0, 1'b0, 0.0, 1'b0);
    send(tag, 3.0, 1'b0, 1'b0, 0.0, 1'b0);
    send(tag, 4.0, 1'b0, 1'b1, 5.0, 1'b0);
    send(tag, -7.0, 1'b0, 1'b0, 0.0, 1'b0);
    send(tag, 9.0, 1'b1, 1'b1, 9.0, 1'b1);
  endtask

  real t3 [18] = '{1.0, 2.0, 100.0, 3.0, 4.0, 100.0, 100.0, 100.0, 100.0,
                   -1.0, -2.0, 50.0, -3.0, -4.0, 50.0, 50.0, 50.0, 50.0};

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 0.0; in_last = 1'b0; out_ready = 1'b1;
    cfg(1'b0, 1'b0, 4'd0, 5'd0, 5'd0);

    // Reset state
    @(posedge clk); #1;
    chk_l("rst in_ready", in_ready, 1'b0);
    chk_l("rst out_valid", out_valid, 1'b0);
    chk_l("rst out_last", out_last, 1'b0);
    chk_r("rst out_data", out_data, 0.0);
    chk_l("rst frame_err", frame_err, 1'b0);
    rst = 1'b0;
    #1;
    chk_l("post-rst in_ready", in_ready, 1'b1);

    // 1: ReLU pass-through
    cfg(1'b1, 1'b0, 4'd0, 5'd0, 5'd3);
    send("t1", -1.5, 1'b0, 1'b1, 0.0, 1'b0);
    send("t1", 2.0, 1'b0, 1'b1, 2.0, 1'b0);
    send("t1", -0.0, 1'b0, 1'b1, 0.0, 1'b0);
    send("t1", 3.25, 1'b1, 1'b1, 3.25, 1'b1);
    @(posedge clk); #1;
    chk_l("t1 drain out_valid", out_valid, 1'b0);
    chk_l("t1 frame_err", frame_err, 1'b0);

    // 2: 2x4 pooling
    cfg(1'b0, 1'b1, 4'd0, 5'd1, 5'd3);
    test2_frame("t2");
    chk_l("t2 frame_err", frame_err, 1'b0);

    // 3: 3x3 two channels, trailing row/column dropped
    cfg(1'b0, 1'b1, 4'd1, 5'd2, 5'd2);
    for (int i = 0; i < 18; i++)
      send("t3", t3[i], i == 17, (i == 4) || (i == 13), (i == 4) ? 4.0 : -1.0, i == 13);
    chk_l("t3 frame_err", frame_err, 1'b0);

    // 4: stall on the first pooled output of the test-2 frame
    cfg(1'b0, 1'b1, 4'd0, 5'd1, 5'd3);
    out_ready = 1'b0;
    send("t4", 1.0, 1'b0, 1'b0, 0.0, 1'b0);
    send("t4", 5.0, 1'b0, 1'b0, 0.0, 1'b0);
    send("t4", 2.0, 1'b0, 1'b0, 0.0, 1'b0);
    send("t4", 0.0, 1'b0, 1'b0, 0.0, 1'b0);
    send("t4", 3.0, 1'b0, 1'b0, 0.0, 1'b0);
    send("t4", 4.0, 1'b0, 1'b1, 5.0, 1'b0);
    in_valid = 1'b1; in_data = -7.0; in_last = 1'b0;
    #1;
    chk_l("t4 stall in_ready", in_ready, 1'b0);
    repeat (5) begin
      @(posedge clk); #1;
      chk_l("t4 hold out_valid", out_valid, 1'b1);
      chk_r("t4 hold out_data", out_data, 5.0);
      chk_l("t4 hold in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    #1;
    chk_l("t4 release in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk_l("t4 release out_valid", out_valid, 1'b0);
    send("t4", 9.0, 1'b1, 1'b1, 9.0, 1'b1);

    // 5: early in_last, then a clean frame from zeroed counters
    cfg(1'b0, 1'b0, 4'd0, 5'd0, 5'd3);
    send("t5", 10.0, 1'b0, 1'b1, 10.0, 1'b0);
    send("t5", 20.0, 1'b1, 1'b1, 20.0, 1'b1);
    chk_l("t5 frame_err", frame_err, 1'b1);
    send("t5b", 1.0, 1'b0, 1'b1, 1.0, 1'b0);
    send("t5b", 2.0, 1'b0, 1'b1, 2.0, 1'b0);
    send("t5b", 3.0, 1'b0, 1'b1, 3.0, 1'b0);
    send("t5b", 4.0, 1'b1, 1'b1, 4.0, 1'b1);
    chk_l("t5b frame_err sticky", frame_err, 1'b1);

    // 6: reset after three accepts of the test-2 frame
    cfg(1'b0, 1'b1, 4'd0, 5'd1, 5'd3);
    send("t6", 1.0, 1'b0, 1'b0, 0.0, 1'b0);
    send("t6", 5.0, 1'b0, 1'b0, 0.0, 1'b0);
    send("t6", 2.0, 1'b0, 1'b0, 0.0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_l("t6 rst out_valid", out_valid, 1'b0);
    chk_l("t6 rst frame_err", frame_err, 1'b0);
    chk_l("t6 rst in_ready", in_ready, 1'b0);
    rst = 1'b0;
    test2_frame("t6b");
    chk_l("t6b frame_err", frame_err, 1'b0);

    // 7: final element without in_last
    cfg(1'b0, 1'b0, 4'd0, 5'd0, 5'd1);
    send("t7", 1.0, 1'b0, 1'b1, 1.0, 1'b0);
    send("t7", 2.0, 1'b0, 1'b1, 2.0, 1'b1);
    chk_l("t7 frame_err", frame_err, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
